fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline. Owns the PC and drives the byte address into
//  the combinational instruction memory. Captures the returned word into the IF/ID
//  register. Handles stall, EX-stage branch redirect/flush, in-fetch J redirect, and HALT.
//  Feeds the decode stage and exposes a halted flag and a fetch counter to the testbench.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  HALT_WORD  32'hB422_1820  instruction word that terminates the program
//  NOP_WORD   32'h0000_0000  bubble injected into IF/ID on flush/halt
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  stall          in   1   hazard unit: hold PC and IF/ID this cycle
//  branch_taken   in   1   EX stage resolved a taken branch (BEQ/BGT...)
//  branch_target  in   32  byte address of branch destination
//  inst_in        in   32  instruction word from imem, same cycle as pc_out
//  pc_out         out  32  current PC (byte address) to imem
//  if_id_instr    out  32  registered instruction to decode
//  if_id_pc4      out  32  registered PC+4 of that instruction
//  if_id_valid    out  1   IF/ID holds a real instruction (0 = bubble)
//  halted         out  1   HALT has been fetched; fetch frozen
//  fetch_count    out  32  number of instructions written into IF/ID with valid=1
// BEHAVIOUR
//  Reset (the clock edge with reset=1):
//   pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, halted=0,
//   fetch_count=0, state=RUN. Reset mid-program discards everything. There is no residual state.
//  FSM: RUN, HALTED. halted output = (state==HALTED), registered.
//  Per-edge priority when not in reset:
//   1 branch_taken: pc<=branch_target & ~3; IF/ID<=NOP_WORD/valid=0; state<=RUN.
//     Overrides stall and HALTED, because a HALT fetched on a wrong path is squashed.
//   2 stall: pc, IF/ID, state and fetch_count all hold.
//   3 HALTED: pc holds; IF/ID<=NOP_WORD, valid=0 every cycle.
//   4 RUN, inst_in==HALT_WORD: IF/ID<=inst_in, pc4=pc+4, valid=1; pc holds;
//     state<=HALTED; fetch_count+1.
//   5 RUN, inst_in[31:26]==OP_J: IF/ID<=inst_in, valid=1;
//     pc<={pc4[31:28],inst_in[25:0],2'b00}; fetch_count+1. There is no delay slot.
//   6 RUN otherwise: IF/ID<=inst_in, pc4=pc+4, valid=1; pc<=pc+4; fetch_count+1.
//  Latency: an instruction at pc appears on if_id_* one edge after pc_out=pc.
//   A J target is fetched on the next cycle, with no bubble.
//   A taken branch costs the bubble inserted here plus whatever decode flushes.
//  Arithmetic: pc+4 and fetch_count wrap modulo 2^32. pc[1:0] is always 0.
//  pc_out = pc register. It is never combinationally dependent on inst_in.
//  Simultaneous branch_taken with a HALT or J on inst_in: the branch wins.
//   The HALT/J word is discarded and is not counted.
// STRUCTURE
//  Shared package (mips_pkg): OP_J=6'b000010, HALT_WORD, NOP_WORD, RESET_PC default,
//   and the opcode field slice constants [31:26], [25:0].
//  One sub-module is natural: if_id_reg. It is a 64-bit+valid register with enable
//   (=~stall) and a synchronous flush that loads NOP_WORD/0/0.
//  The PC mux, FSM and counter live in fetch_stage.
// TESTING
//  T1 Reset: assert reset 2 cycles with random inputs
//     -> pc_out=0, if_id_valid=0, if_id_instr=0, halted=0, fetch_count=0.
//  T2 Sequential: imem ADD/ADDI/SUB at 0,4,8
//     -> pc_out 0,4,8,12 on successive cycles.
//     -> if_id_pc4 4,8,12 lagging by one cycle; fetch_count=3.
//  T3 Stall: stall=1 for 3 cycles at pc=8
//     -> pc_out stays 8; if_id_instr/pc4 unchanged; fetch_count unchanged.
//     -> Resumes at 12 after release.
//  T4 Jump: word 32'h0800_0002 at pc=24
//     -> next pc_out=8; if_id_instr=32'h0800_0002 with pc4=28, valid=1.
//  T5 Branch: branch_taken=1, target=28, together with stall=1 at pc=20
//     -> next pc_out=28; if_id_valid=0, if_id_instr=0.
//  T6 Halt: HALT_WORD at pc=40
//     -> IF/ID holds it with valid=1; halted=1; pc_out frozen at 40.
//     -> Subsequent if_id_valid=0.
//     -> A later branch_taken to 8 clears halted and fetches from 8.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcode field positions, special instruction words,
// the fetch FSM encoding and the jump-target helper.
package mips_pkg;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned TGT_MSB = 25;
    localparam int unsigned TGT_LSB = 0;

    localparam logic [5:0]  OP_J          = 6'b000010;
    localparam logic [31:0] DEF_HALT_WORD = 32'hB422_1820;
    localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    // J target: 256 MB region of the following instruction, word index from the instruction.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] word_idx);
        return {region, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Flush (bubble insertion) takes priority over the load enable.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Reset/flush load a bubble; otherwise load when enabled, hold when not.
    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_instr <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, chooses the next PC (sequential, J, branch redirect),
// runs the RUN/HALTED FSM and counts instructions delivered to decode.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
    parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc4;
    logic         w_load;
    logic         w_flush;
    logic         w_is_halt;
    logic         w_is_jump;

    assign w_pc4     = r_pc + 32'd4;
    assign w_is_halt = (inst_in == HALT_WORD);
    assign w_is_jump = (inst_in[OP_MSB:OP_LSB] == OP_J);

    // State register, PC and fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Next-state logic: a redirect always returns to RUN; HALT only latches from RUN.
    always_comb begin
        w_state_next = r_state;
        if (branch_taken) begin
            w_state_next = ST_RUN;
        end else if (stall) begin
            w_state_next = r_state;
        end else begin
            case (r_state)
                ST_RUN:    w_state_next = w_is_halt ? ST_HALTED : ST_RUN;
                ST_HALTED: w_state_next = ST_HALTED;
                default:   w_state_next = ST_RUN;
            endcase
        end
    end

    // Output logic: next PC and IF/ID load/flush controls, in priority order.
    always_comb begin
        w_pc_next = r_pc;
        w_load    = 1'b0;
        w_flush   = 1'b0;
        if (branch_taken) begin
            w_pc_next = branch_target & ~32'd3;
            w_flush   = 1'b1;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_load = 1'b1;
                    if (w_is_halt) begin
                        w_pc_next = r_pc;
                    end else if (w_is_jump) begin
                        w_pc_next = jump_target(w_pc4[31:28], inst_in[TGT_MSB:TGT_LSB]);
                    end else begin
                        w_pc_next = w_pc4;
                    end
                end
                ST_HALTED: begin
                    w_flush = 1'b1;
                end
                default: begin
                    w_flush = 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk     (clk),
        .i_reset (reset),
        .i_en    (w_load),
        .i_flush (w_flush),
        .i_instr (inst_in),
        .i_pc4   (w_pc4),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid)
    );

    assign pc_out      = r_pc;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with constant
// expectations plus a randomized run against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] HALT   = 32'hB422_1820;
    localparam logic [31:0] W_ADD  = 32'h0022_1820;
    localparam logic [31:0] W_ADDI = 32'h2001_0005;
    localparam logic [31:0] W_SUB  = 32'h0022_1822;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] inst_in = 32'd0;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];

    // behavioural model of the stage
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4 = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    logic [31:0] m_count = 32'd0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst_in       (inst_in),
        .pc_out        (pc_out),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic load_default();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0020 | (i << 11);
        mem[0] = W_ADD;
        mem[1] = W_ADDI;
        mem[2] = W_SUB;
    endtask

    // One clock: imem answers for the model's PC, then the model applies the edge rules.
    task automatic tick();
        logic [31:0] nxt;
        inst_in = mem[m_pc[7:2]];
        @(posedge clk);
        if (reset) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
            m_valid = 1'b0; m_halted = 1'b0; m_count = 32'd0;
        end else if (branch_taken) begin
            m_pc = {branch_target[31:2], 2'b00};
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (m_halted) begin
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else begin
            nxt = m_pc + 32'd4;
            m_instr = inst_in; m_pc4 = nxt; m_valid = 1'b1; m_count = m_count + 32'd1;
            if (inst_in == HALT) m_halted = 1'b1;
            else if (inst_in[31:26] == 6'd2) m_pc = {nxt[31:28], inst_in[25:0], 2'b00};
            else m_pc = nxt;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            stall = 1'($urandom); branch_taken = 1'($urandom); branch_target = $urandom;
            tick();
            n_vec++; if (pc_out !== 32'd0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc_out); end
            n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
            n_vec++; if (if_id_instr !== 32'd0) begin n_err++; $display("FAIL reset_instr got %h want 0", if_id_instr); end
            n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
            n_vec++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        end
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_sequential();
        load_default();
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_vec++; if (pc_out !== 32'(4 * c)) begin n_err++; $display("FAIL seq_pc got %0d want %0d", pc_out, 4 * c); end
            n_vec++; if (if_id_pc4 !== 32'(4 * c)) begin n_err++; $display("FAIL seq_pc4 got %0d want %0d", if_id_pc4, 4 * c); end
            n_vec++; if (if_id_instr !== mem[c - 1]) begin n_err++; $display("FAIL seq_instr got %h want %h", if_id_instr, mem[c - 1]); end
        end
        n_vec++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL seq_count got %0d want 3", fetch_count); end
    endtask

    task automatic test_stall();
        load_default();
        do_reset();
        tick(); tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (pc_out !== 32'd8) begin n_err++; $display("FAIL stall_pc got %0d want 8", pc_out); end
            n_vec++; if (if_id_instr !== W_ADDI || if_id_pc4 !== 32'd8) begin n_err++; $display("FAIL stall_ifid got %h/%0d want %h/8", if_id_instr, if_id_pc4, W_ADDI); end
            n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL stall_count got %0d want 2", fetch_count); end
        end
        stall = 1'b0;
        tick();
        n_vec++; if (pc_out !== 32'd12 || if_id_instr !== W_SUB || if_id_pc4 !== 32'd12) begin n_err++; $display("FAIL stall_resume got pc %0d instr %h want pc 12 instr %h", pc_out, if_id_instr, W_SUB); end
    endtask

    task automatic test_jump();
        load_default();
        mem[6] = 32'h0800_0002;
        do_reset();
        for (int c = 0; c < 6; c++) tick();
        n_vec++; if (pc_out !== 32'd24) begin n_err++; $display("FAIL jump_setup got %0d want 24", pc_out); end
        tick();
        n_vec++; if (pc_out !== 32'd8) begin n_err++; $display("FAIL jump_pc got %0d want 8", pc_out); end
        n_vec++; if (if_id_instr !== 32'h0800_0002 || if_id_pc4 !== 32'd28 || if_id_valid !== 1'b1) begin n_err++; $display("FAIL jump_ifid got %h/%0d/%b want 08000002/28/1", if_id_instr, if_id_pc4, if_id_valid); end
        tick();
        n_vec++; if (if_id_instr !== W_SUB || if_id_valid !== 1'b1 || if_id_pc4 !== 32'd12) begin n_err++; $display("FAIL jump_nobubble got %h/%b want %h/1", if_id_instr, if_id_valid, W_SUB); end
        n_vec++; if (fetch_count !== 32'd8) begin n_err++; $display("FAIL jump_count got %0d want 8", fetch_count); end
    endtask

    task automatic test_branch();
        load_default();
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd28;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        n_vec++; if (pc_out !== 32'd28) begin n_err++; $display("FAIL br_pc got %0d want 28", pc_out); end
        n_vec++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0) begin n_err++; $display("FAIL br_bubble got %b/%h want 0/0", if_id_valid, if_id_instr); end
        n_vec++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL br_count got %0d want 5", fetch_count); end
        branch_taken = 1'b1; branch_target = 32'h0000_0013;
        tick();
        branch_taken = 1'b0;
        n_vec++; if (pc_out !== 32'd16) begin n_err++; $display("FAIL br_align got %h want 10", pc_out); end
        // branch beats a J word on inst_in: J discarded, not counted
        mem[4] = 32'h0800_0001;
        branch_taken = 1'b1; branch_target = 32'd40;
        tick();
        branch_taken = 1'b0;
        n_vec++; if (pc_out !== 32'd40 || fetch_count !== 32'd5) begin n_err++; $display("FAIL br_vs_j got pc %0d cnt %0d want 40/5", pc_out, fetch_count); end
    endtask

    task automatic test_halt();
        load_default();
        mem[10] = HALT;
        do_reset();
        for (int c = 0; c < 10; c++) tick();
        tick();
        n_vec++; if (if_id_instr !== HALT || if_id_valid !== 1'b1 || if_id_pc4 !== 32'd44) begin n_err++; $display("FAIL halt_ifid got %h/%b/%0d want %h/1/44", if_id_instr, if_id_valid, if_id_pc4, HALT); end
        n_vec++; if (halted !== 1'b1 || pc_out !== 32'd40) begin n_err++; $display("FAIL halt_state got %b pc %0d want 1 pc 40", halted, pc_out); end
        n_vec++; if (fetch_count !== 32'd11) begin n_err++; $display("FAIL halt_count got %0d want 11", fetch_count); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || pc_out !== 32'd40 || fetch_count !== 32'd11) begin n_err++; $display("FAIL halt_frozen got %b/%h pc %0d cnt %0d want 0/0 pc 40 cnt 11", if_id_valid, if_id_instr, pc_out, fetch_count); end
        end
        branch_taken = 1'b1; branch_target = 32'd8;
        tick();
        branch_taken = 1'b0;
        n_vec++; if (halted !== 1'b0 || pc_out !== 32'd8) begin n_err++; $display("FAIL halt_exit got %b pc %0d want 0 pc 8", halted, pc_out); end
        tick();
        n_vec++; if (if_id_instr !== W_SUB || if_id_valid !== 1'b1 || pc_out !== 32'd12) begin n_err++; $display("FAIL halt_refetch got %h/%b pc %0d want %h/1 pc 12", if_id_instr, if_id_valid, pc_out, W_SUB); end
    endtask

    task automatic test_wrap();
        load_default();
        mem[1] = 32'h0800_0003;
        do_reset();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        n_vec++; if (pc_out !== 32'd0 || if_id_pc4 !== 32'd0 || if_id_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pc got pc %h pc4 %h want 0/0", pc_out, if_id_pc4); end
        branch_taken = 1'b1; branch_target = 32'h7000_0004;
        tick();
        branch_taken = 1'b0;
        tick();
        n_vec++; if (pc_out !== 32'h7000_000C) begin n_err++; $display("FAIL j_region got %h want 7000000c", pc_out); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       mem[i] = HALT;
            else if (r < 17) mem[i] = {6'd2, 20'd0, 6'($urandom_range(0, 63))};
            else             mem[i] = {6'd0, 20'($urandom), 6'h20};
        end
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset         = ($urandom_range(0, 99) < 2);
            stall         = ($urandom_range(0, 99) < 20);
            branch_taken  = ($urandom_range(0, 99) < 10);
            branch_target = 32'($urandom_range(0, 255));
            tick();
            n_vec++;
            if (pc_out !== m_pc || if_id_instr !== m_instr || if_id_pc4 !== m_pc4 ||
                if_id_valid !== m_valid || halted !== m_halted || fetch_count !== m_count) begin
                n_err++;
                $display("FAIL rand_cycle%0d got pc %h ins %h pc4 %h v %b h %b cnt %0d want pc %h ins %h pc4 %h v %b h %b cnt %0d",
                         c, pc_out, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count,
                         m_pc, m_instr, m_pc4, m_valid, m_halted, m_count);
            end
        end
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch();
        test_halt();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
